// File: rtl/swt16_pkg.sv
// Shared definitions for the swt16 core: default PC geometry, boot/trap vectors
// and the fetch sequencer state encoding.
`timescale 1ns/1ps
package swt16_pkg;

  localparam int          DEFAULT_PC_WIDTH     = 12;
  localparam logic [11:0] DEFAULT_RESET_PC     = 12'h000;
  localparam logic [11:0] DEFAULT_TRAP_PC      = 12'h0F0;
  localparam int          DEFAULT_FLUSH_CYCLES = 2;

  typedef enum logic [1:0] {
    FC_BOOT  = 2'd0,
    FC_RUN   = 2'd1,
    FC_FLUSH = 2'd2,
    FC_HALT  = 2'd3
  } fetch_state_e;

  // Width of a down-counter able to hold the value 'cycles'.
  function automatic int timerWidth(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/fetch_ctrl_flush_timer.sv
// flush_timer: loads FLUSH_CYCLES-1 on a redirect, counts down while ticked and
// flags the final flush cycle. Saturates at zero.
`timescale 1ns/1ps
module flush_timer
  import swt16_pkg::*;
#(
  parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
  localparam int CW = timerWidth(FLUSH_CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  logic i_tick,
  output logic o_done
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(FLUSH_CYCLES - 1);
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  // A count of 0 is also treated as done so the sequencer can never stick in FLUSH.
  assign o_done = (r_count <= CW'(1));

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer arbitrating boot, trap/branch redirects, stalls and halt.
// Optional trap support is enabled by defining FETCH_CTRL_TRAP_EN.
`timescale 1ns/1ps
module fetch_ctrl
  import swt16_pkg::*;
#(
  parameter int                    PC_WIDTH     = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]   RESET_PC     = PC_WIDTH'(DEFAULT_RESET_PC),
  parameter logic [PC_WIDTH-1:0]   TRAP_PC      = PC_WIDTH'(DEFAULT_TRAP_PC),
  parameter int                    FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] in_fe_pc,
  input  logic                in_branch_taken,
  input  logic [PC_WIDTH-1:0] in_branch_target,
  input  logic                in_trap_req,
  input  logic                in_stall,
  input  logic                in_halt,
  input  logic                in_resume,
  output logic                out_set_pc,
  output logic [PC_WIDTH-1:0] out_branch_pc,
  output logic                out_flush,
  output logic [PC_WIDTH-1:0] out_epc,
  output logic                out_halted
);

  fetch_state_e        r_state;
  fetch_state_e        w_nextState;
  logic                w_trapReq;
  logic                w_redirect;
  logic [PC_WIDTH-1:0] w_redirectPc;
  logic                w_load;
  logic                w_tick;
  logic                w_done;
  logic                w_captureEpc;

`ifdef FETCH_CTRL_TRAP_EN
  assign w_trapReq = in_trap_req;
`else
  logic w_unusedTrap;
  assign w_trapReq    = 1'b0;
  assign w_unusedTrap = ^{in_trap_req, w_captureEpc};
`endif

  assign w_redirect   = w_trapReq | in_branch_taken;
  assign w_redirectPc = w_trapReq ? TRAP_PC : in_branch_target;

  flush_timer #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flushTimer (
    .clock (clock),
    .reset (reset),
    .i_load(w_load),
    .i_tick(w_tick),
    .o_done(w_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= FC_BOOT;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    out_set_pc    = 1'b0;
    out_branch_pc = in_fe_pc;
    out_flush     = 1'b0;
    out_halted    = 1'b0;
    w_load        = 1'b0;
    w_tick        = 1'b0;
    w_captureEpc  = 1'b0;

    case (r_state)
      FC_BOOT: begin
        out_set_pc    = 1'b1;
        out_branch_pc = RESET_PC;
        out_flush     = 1'b1;
        w_load        = 1'b1;
        if (FLUSH_CYCLES == 1) w_nextState = FC_RUN;
        else                   w_nextState = FC_FLUSH;
      end

      FC_RUN, FC_FLUSH: begin
        // Trap/branch redirects are honoured in both states; halt and stall only in RUN.
        if (w_redirect) begin
          out_set_pc    = 1'b1;
          out_branch_pc = w_redirectPc;
          out_flush     = 1'b1;
          w_load        = 1'b1;
          w_captureEpc  = w_trapReq;
          if (FLUSH_CYCLES == 1) w_nextState = FC_RUN;
          else                   w_nextState = FC_FLUSH;
        end else if (r_state == FC_FLUSH) begin
          out_flush = 1'b1;
          w_tick    = 1'b1;
          if (w_done) w_nextState = FC_RUN;
        end else if (in_halt) begin
          out_set_pc  = 1'b1;
          out_flush   = 1'b1;
          w_nextState = FC_HALT;
        end else if (in_stall) begin
          out_set_pc = 1'b1;
          out_flush  = 1'b1;
        end
      end

      FC_HALT: begin
        out_set_pc = 1'b1;
        out_flush  = 1'b1;
        out_halted = 1'b1;
        if (in_resume) w_nextState = FC_RUN;
      end

      default: begin
        w_nextState = FC_BOOT;
      end
    endcase

    if (!reset) begin
      out_set_pc    = 1'b0;
      out_branch_pc = '0;
      out_flush     = 1'b1;
      out_halted    = 1'b0;
      w_load        = 1'b0;
      w_tick        = 1'b0;
      w_captureEpc  = 1'b0;
    end
  end

`ifdef FETCH_CTRL_TRAP_EN
  logic [PC_WIDTH-1:0] r_epc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_epc <= '0;
    end else if (w_captureEpc) begin
      r_epc <= in_fe_pc;
    end
  end

  assign out_epc = r_epc;
`else
  assign out_epc = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_fetch_ctrl;

  localparam int          PCW = 12;
  localparam logic [11:0] RPC = 12'h000;
  localparam logic [11:0] TPC = 12'h0F0;
  localparam int          FC  = 2;
`ifdef FETCH_CTRL_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [PCW-1:0] in_fe_pc = '0;
  logic           in_branch_taken = 1'b0;
  logic [PCW-1:0] in_branch_target = '0;
  logic           in_trap_req = 1'b0;
  logic           in_stall = 1'b0;
  logic           in_halt = 1'b0;
  logic           in_resume = 1'b0;
  logic           out_set_pc;
  logic [PCW-1:0] out_branch_pc;
  logic           out_flush;
  logic [PCW-1:0] out_epc;
  logic           out_halted;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clock = ~clock;

  fetch_ctrl #(
    .PC_WIDTH    (PCW),
    .RESET_PC    (RPC),
    .TRAP_PC     (TPC),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_fe_pc        (in_fe_pc),
    .in_branch_taken (in_branch_taken),
    .in_branch_target(in_branch_target),
    .in_trap_req     (in_trap_req),
    .in_stall        (in_stall),
    .in_halt         (in_halt),
    .in_resume       (in_resume),
    .out_set_pc      (out_set_pc),
    .out_branch_pc   (out_branch_pc),
    .out_flush       (out_flush),
    .out_epc         (out_epc),
    .out_halted      (out_halted)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic br, input logic [11:0] tgt,
                               input logic trap, input logic stall, input logic halt,
                               input logic resume, input logic [11:0] fepc);
    @(posedge clock);
    #1;
    reset            = rst;
    in_branch_taken  = br;
    in_branch_target = tgt;
    in_trap_req      = trap;
    in_stall         = stall;
    in_halt          = halt;
    in_resume        = resume;
    in_fe_pc         = fepc;
  endtask

  task automatic expectOut(input string tag, input logic sp, input logic [11:0] pc,
                           input logic fl, input logic hl);
    @(negedge clock);
    checkOutput({tag, "_set_pc"}, 32'(out_set_pc), 32'(sp));
    checkOutput({tag, "_flush"}, 32'(out_flush), 32'(fl));
    checkOutput({tag, "_halted"}, 32'(out_halted), 32'(hl));
    if (sp) checkOutput({tag, "_pc"}, 32'(out_branch_pc), 32'(pc));
  endtask

  // Model: a boot flag, a halted flag and the number of flush-only cycles still owed.
  logic        mBoot      = 1'b1;
  logic        mHalted    = 1'b0;
  int          mFlushLeft = 0;
  logic [11:0] mEpc       = '0;

  always @(negedge clock) begin : model
    logic        eSp, eFl, eHl;
    logic [11:0] ePc, eEpc;
    logic        trapHit;
    eSp = 1'b0; eFl = 1'b0; eHl = 1'b0; ePc = '0; eEpc = mEpc;
    trapHit = TRAP_ON && in_trap_req;
    if (!reset) begin
      eFl = 1'b1; eEpc = '0;
      mBoot = 1'b1; mHalted = 1'b0; mFlushLeft = 0; mEpc = '0;
    end else if (mBoot) begin
      eSp = 1'b1; ePc = RPC; eFl = 1'b1;
      mBoot = 1'b0; mFlushLeft = FC - 1;
    end else if (mHalted) begin
      eSp = 1'b1; ePc = in_fe_pc; eFl = 1'b1; eHl = 1'b1;
      if (in_resume) mHalted = 1'b0;
    end else if (trapHit || in_branch_taken) begin
      eSp = 1'b1; eFl = 1'b1;
      ePc = trapHit ? TPC : in_branch_target;
      if (trapHit) mEpc = in_fe_pc;
      mFlushLeft = FC - 1;
    end else if (mFlushLeft > 0) begin
      eFl = 1'b1;
      mFlushLeft--;
    end else if (in_halt) begin
      eSp = 1'b1; ePc = in_fe_pc; eFl = 1'b1;
      mHalted = 1'b1;
    end else if (in_stall) begin
      eSp = 1'b1; ePc = in_fe_pc; eFl = 1'b1;
    end
    checkOutput("m_set_pc", 32'(out_set_pc), 32'(eSp));
    checkOutput("m_flush", 32'(out_flush), 32'(eFl));
    checkOutput("m_halted", 32'(out_halted), 32'(eHl));
    checkOutput("m_epc", 32'(out_epc), 32'(eEpc));
    if (eSp || !reset) checkOutput("m_branch_pc", 32'(out_branch_pc), 32'(ePc));
  end

  initial begin
    repeat (3) @(posedge clock);
    expectOut("reset", 1'b0, 12'h000, 1'b1, 1'b0);
    checkOutput("reset_epc", 32'(out_epc), 32'h0);

    applyStimulus(1, 0, 12'h000, 0, 0, 0, 0, 12'h000);
    expectOut("boot", 1'b1, RPC, 1'b1, 1'b0);
    applyStimulus(1, 0, 12'h000, 0, 0, 0, 0, 12'h000);
    expectOut("boot_flush", 1'b0, 12'h000, 1'b1, 1'b0);
    applyStimulus(1, 0, 12'h000, 0, 0, 0, 0, 12'h001);
    expectOut("boot_run", 1'b0, 12'h000, 1'b0, 1'b0);

    applyStimulus(1, 1, 12'h080, 0, 0, 0, 0, 12'h010);
    expectOut("branch", 1'b1, 12'h080, 1'b1, 1'b0);
    applyStimulus(1, 0, 12'h000, 0, 0, 0, 0, 12'h080);
    expectOut("branch_flush", 1'b0, 12'h000, 1'b1, 1'b0);
    applyStimulus(1, 0, 12'h000, 0, 0, 0, 0, 12'h081);
    expectOut("branch_run", 1'b0, 12'h000, 1'b0, 1'b0);

    applyStimulus(1, 1, 12'h080, 0, 0, 0, 0, 12'h010);
    expectOut("br1", 1'b1, 12'h080, 1'b1, 1'b0);
    applyStimulus(1, 1, 12'h0A0, 0, 1, 1, 0, 12'h080);
    expectOut("br2", 1'b1, 12'h0A0, 1'b1, 1'b0);
    applyStimulus(1, 0, 12'h000, 0, 0, 0, 0, 12'h0A0);
    expectOut("br2_flush", 1'b0, 12'h000, 1'b1, 1'b0);
    applyStimulus(1, 0, 12'h000, 0, 0, 0, 0, 12'h0A1);
    expectOut("br2_run", 1'b0, 12'h000, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 12'h000, 0, 1, 0, 0, 12'h020);
      expectOut("stall", 1'b1, 12'h020, 1'b1, 1'b0);
    end
    applyStimulus(1, 0, 12'h000, 0, 0, 0, 0, 12'h020);
    expectOut("stall_end", 1'b0, 12'h000, 1'b0, 1'b0);

    applyStimulus(1, 1, 12'h080, 1, 0, 0, 0, 12'h044);
    expectOut("trap", 1'b1, TRAP_ON ? TPC : 12'h080, 1'b1, 1'b0);
    applyStimulus(1, 0, 12'h000, 0, 0, 0, 0, 12'h0F0);
    expectOut("trap_flush", 1'b0, 12'h000, 1'b1, 1'b0);
    checkOutput("trap_epc", 32'(out_epc), TRAP_ON ? 32'h044 : 32'h0);
    applyStimulus(1, 0, 12'h000, 0, 0, 0, 0, 12'h0F1);
    expectOut("trap_run", 1'b0, 12'h000, 1'b0, 1'b0);

    applyStimulus(1, 0, 12'h000, 0, 0, 1, 0, 12'h030);
    expectOut("halt_enter", 1'b1, 12'h030, 1'b1, 1'b0);
    applyStimulus(1, 0, 12'h000, 0, 0, 1, 0, 12'h030);
    expectOut("halted", 1'b1, 12'h030, 1'b1, 1'b1);
    applyStimulus(1, 1, 12'h0C0, 1, 0, 1, 0, 12'h030);
    expectOut("halt_ignores", 1'b1, 12'h030, 1'b1, 1'b1);
    applyStimulus(0, 0, 12'h000, 0, 0, 1, 0, 12'h030);
    expectOut("halt_reset", 1'b0, 12'h000, 1'b1, 1'b0);
    checkOutput("halt_reset_epc", 32'(out_epc), 32'h0);
    applyStimulus(1, 0, 12'h000, 0, 0, 0, 0, 12'h030);
    expectOut("reboot", 1'b1, RPC, 1'b1, 1'b0);
    applyStimulus(1, 0, 12'h000, 0, 0, 0, 0, 12'h000);
    expectOut("reboot_flush", 1'b0, 12'h000, 1'b1, 1'b0);
    applyStimulus(1, 0, 12'h000, 0, 0, 1, 0, 12'h030);
    expectOut("halt2_enter", 1'b1, 12'h030, 1'b1, 1'b0);
    applyStimulus(1, 0, 12'h000, 0, 0, 1, 0, 12'h030);
    expectOut("halt2", 1'b1, 12'h030, 1'b1, 1'b1);
    applyStimulus(1, 0, 12'h000, 0, 0, 0, 1, 12'h030);
    expectOut("resume", 1'b1, 12'h030, 1'b1, 1'b1);
    applyStimulus(1, 0, 12'h000, 0, 0, 0, 0, 12'h030);
    expectOut("resumed", 1'b0, 12'h000, 1'b0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(99) != 0,
                    $urandom_range(99) < 15,
                    12'($urandom),
                    $urandom_range(99) < 8,
                    $urandom_range(99) < 15,
                    $urandom_range(99) < 10,
                    $urandom_range(99) < 20,
                    12'($urandom));
    end
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
